weight_loader: RTL
==================

WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 The module SHALL have one parameter line, ADDR_W, default 16, meaning the weight-memory address width in bits.
REQ-002 The module SHALL have one parameter line, DATA_W, default 8, meaning the weight byte width in bits; only DATA_W=8 is supported.
REQ-003 The module SHALL use one clock, clk, and its reset, rst, SHALL be synchronous and active-high.
REQ-004 Port clk SHALL be an input of width 1 and is the only clock.
REQ-005 Port rst SHALL be an input of width 1: synchronous, active-high reset.
REQ-006 Port start SHALL be an input of width 1: request to begin a load.
REQ-007 Port base_addr SHALL be an input of width ADDR_W: first write address, sampled with start.
REQ-008 Port count SHALL be an input of width ADDR_W: number of weight bytes to load, sampled with start.
REQ-009 Port in_data SHALL be an input of width DATA_W: streamed weight byte.
REQ-010 Port in_valid SHALL be an input of width 1: in_data is valid.
REQ-011 Port in_ready SHALL be an output of width 1: loader accepts a byte this cycle.
REQ-012 Port wr_en SHALL be an output of width 1: weight-memory write strobe.
REQ-013 Port wr_addr SHALL be an output of width ADDR_W: weight-memory write address.
REQ-014 Port wr_data SHALL be an output of width DATA_W: weight-memory write data.
REQ-015 Port busy SHALL be an output of width 1: high while a load is in progress.
REQ-016 Port done SHALL be an output of width 1: one-cycle completion pulse.
REQ-017 Port err SHALL be an output of width 1: checksum mismatch flag; it is held 0 when checksum is not compiled in.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, CHECK and DONE; CHECK SHALL be reachable only when WEIGHT_LOADER_CHECKSUM_EN is defined.
REQ-019 In IDLE, start=1 with count>0 SHALL latch base_addr and count, clear the byte index, and enter LOAD on the next cycle.
REQ-020 In IDLE, start=1 with count=0 SHALL produce no writes and enter DONE (or CHECK when checksum is enabled).
REQ-021 Assertion of start in any state other than IDLE SHALL be ignored.
REQ-022 in_ready SHALL be a decode of the registered state: 1 in LOAD and CHECK, 0 otherwise, with no combinational path from in_valid.
REQ-023 A byte SHALL be accepted only in a cycle where in_valid and in_ready are both 1.
REQ-024 A byte accepted in LOAD SHALL produce, on the next cycle, a single-cycle wr_en=1 with wr_addr=(base+idx) mod 2^ADDR_W and wr_data equal to the accepted byte; idx SHALL then increment.
REQ-025 wr_en SHALL be 0 in every cycle not required by REQ-024.
REQ-026 Write addresses SHALL wrap modulo 2^ADDR_W without error.
REQ-027 On acceptance of byte number count, the FSM SHALL leave LOAD for DONE (or CHECK when checksum is enabled).
REQ-028 DONE SHALL last one cycle with done=1 and SHALL return to IDLE; done SHALL be 0 in all other states.
REQ-029 busy SHALL be 1 in LOAD, CHECK and DONE and 0 in IDLE.
REQ-030 A start input arriving in the same cycle as done=1 SHALL be ignored; a new start is honoured from the next IDLE cycle.
REQ-031 When in_valid=0 in LOAD, the FSM SHALL hold state, index and address with no write.

Reset
REQ-032 With rst=1 at a clock edge, the module SHALL enter IDLE and clear idx, the latched base and count, and the checksum.
REQ-033 During reset, outputs SHALL be in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0 and err=0.
REQ-034 Reset SHALL take priority over all other inputs.
REQ-035 Reset applied mid-load SHALL abort the load, with no write issued on the following cycle.

Configuration
REQ-036 When the macro WEIGHT_LOADER_CHECKSUM_EN is defined, the module SHALL keep an XOR over all bytes accepted in LOAD.
REQ-037 With WEIGHT_LOADER_CHECKSUM_EN defined, CHECK SHALL accept exactly one trailing byte, which is not written to memory.
REQ-038 With WEIGHT_LOADER_CHECKSUM_EN defined, err SHALL be set at DONE if the trailing byte differs from the XOR, and SHALL hold until the next accepted start or reset.
REQ-039 When WEIGHT_LOADER_CHECKSUM_EN is undefined, the module SHALL contain no checksum logic and no CHECK state, and err SHALL be tied to 0.

Structure
REQ-040 The FSM state encoding and the ADDR_W/DATA_W defaults SHALL live in a shared package, tpu_pkg, also used by weight_memory.
REQ-041 The module SHALL have no sub-module; the single FSM with a counter is the natural size.

Verification
REQ-042 The bench SHALL cover: base=0x0010, count=4, bytes 11,22,33,44 with in_valid held high -> writes to 0x0010..0x0013 with matching data, each 1 cycle after acceptance, then done for one cycle.
REQ-043 The bench SHALL cover: base=0xFFFE, count=3 -> writes at 0xFFFE, 0xFFFF, 0x0000.
REQ-044 The bench SHALL cover: count=0 -> no wr_en, done one cycle after start, busy high for exactly one cycle.
REQ-045 The bench SHALL cover: in_valid toggling 1,0,0,1 during count=2 -> exactly two writes, with address and index held during the gaps.
REQ-046 The bench SHALL cover: rst asserted after 2 of 4 bytes -> no further wr_en, state IDLE, and a later start with base=0x0020 writes from 0x0020.
REQ-047 The bench SHALL cover, with WEIGHT_LOADER_CHECKSUM_EN defined: bytes 01,02,04 with trailer 07 -> err=0; with trailer 06 -> err=1; the trailer is never written.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared TPU definitions: loader FSM state encoding and default widths.
// Used by weight_loader and weight_memory.
package tpu_pkg;

  localparam int TPU_ADDR_W = 16;
  localparam int TPU_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } wl_state_e;

endpackage

// File: rtl/weight_loader.sv
// Streams count weight bytes into weight memory starting at base_addr.
// Ports: clk, rst (sync, active-high); start/base_addr/count request a
// load; in_data/in_valid/in_ready byte stream; wr_en/wr_addr/wr_data
// memory write port; busy, done (1-cycle pulse), err (checksum flag).
// Option: define WEIGHT_LOADER_CHECKSUM_EN to require a trailing XOR
// byte after the payload; err flags a mismatch, else err is tied 0.
module weight_loader
  import tpu_pkg::*;
#(
  parameter int ADDR_W = TPU_ADDR_W,
  parameter int DATA_W = TPU_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] count,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  localparam wl_state_e TAIL_ST = ST_CHECK;
`else
  localparam wl_state_e TAIL_ST = ST_DONE;
`endif

  wl_state_e         state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
  logic              err_q, err_d;
`endif

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    csum_d    = csum_q;
    err_d     = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d = base_addr;
          cnt_d  = count;
          idx_d  = '0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
          csum_d = '0;
          err_d  = 1'b0;
`endif
          state_d = (count == '0) ? TAIL_ST : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = base_q + idx_q;
          wr_data_d = in_data;
          idx_d     = idx_q + ADDR_W'(1);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
          csum_d    = csum_q ^ in_data;
`endif
          if (idx_d == cnt_q) state_d = TAIL_ST;
        end
      end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        // trailer byte is compared, never written
        if (in_valid) begin
          err_d   = (in_data != csum_q);
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      csum_q    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      csum_q    <= csum_d;
      err_q     <= err_d;
`endif
    end
  end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  assign in_ready = (state_q == ST_LOAD) || (state_q == ST_CHECK);
  assign err      = err_q;
`else
  assign in_ready = (state_q == ST_LOAD);
  assign err      = 1'b0;
`endif
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);

endmodule
